// File: rtl/clock_replacement_controller_pkg.sv
// Shared cache replacement definitions: default geometry, controller FSM
// states and the per-set replacement state record.
package clock_replacement_controller_pkg;

    localparam int DEF_ASSOCIATIVITY = 4;
    localparam int DEF_NUM_SETS      = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RESP   = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic [DEF_ASSOCIATIVITY-1:0] pointer;
        logic [DEF_ASSOCIATIVITY-1:0] use_bits;
    } set_state_t;

endpackage

// File: rtl/ClockReplacement.sv
// Combinational clock (second-chance) policy: scans from the pointer, clearing
// use bits of passed ways, and evicts the first way with a clear use bit.
module ClockReplacement #(
    parameter int ASSOCIATIVITY = 4
) (
    input  logic [ASSOCIATIVITY-1:0] pointer,
    input  logic [ASSOCIATIVITY-1:0] use_bits,
    output logic [ASSOCIATIVITY-1:0] evicted_block_mask,
    output logic [ASSOCIATIVITY-1:0] clock_use_if_evict
);

    localparam int IDX_W = $clog2(ASSOCIATIVITY);

    logic [IDX_W-1:0]         ptr_idx_s;
    logic [IDX_W-1:0]         idx_s;
    logic                     found_s;
    logic [ASSOCIATIVITY-1:0] mask_s;
    logic [ASSOCIATIVITY-1:0] use_s;

    // Scan ways in clock order; when every way is in use the pointer way is taken.
    always_comb begin
        ptr_idx_s = {IDX_W{1'b0}};
        idx_s     = {IDX_W{1'b0}};
        found_s   = 1'b0;
        mask_s    = {ASSOCIATIVITY{1'b0}};
        use_s     = use_bits;
        for (int i = 0; i < ASSOCIATIVITY; i++) begin
            if (pointer[i]) begin
                ptr_idx_s = IDX_W'(i);
            end else begin
                ptr_idx_s = ptr_idx_s;
            end
        end
        for (int k = 0; k < ASSOCIATIVITY; k++) begin
            idx_s = ptr_idx_s + IDX_W'(k);
            if (found_s) begin
                found_s = 1'b1;
            end else if (use_bits[idx_s]) begin
                use_s[idx_s] = 1'b0;
            end else begin
                mask_s[idx_s] = 1'b1;
                found_s       = 1'b1;
            end
        end
        if (!found_s) begin
            mask_s = pointer;
        end else begin
            mask_s = mask_s;
        end
    end

    assign evicted_block_mask = mask_s;
    assign clock_use_if_evict = use_s | mask_s;

endmodule

// File: rtl/FindFirstOneFromLsb.sv
// Isolates the lowest set bit of a vector as a one-hot mask.
module FindFirstOneFromLsb #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] vec,
    output logic [WIDTH-1:0] first_one,
    output logic             found
);

    assign first_one = vec & (~vec + WIDTH'(1));
    assign found     = |vec;

endmodule

// File: rtl/replacement_state_array.sv
// Per-set clock pointer and use-bit storage with one read port and merged
// hit/commit write ports.
module replacement_state_array #(
    parameter  int ASSOCIATIVITY = 4,
    parameter  int NUM_SETS      = 16,
    localparam int SET_W         = $clog2(NUM_SETS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SET_W-1:0]         rd_set,
    output logic [ASSOCIATIVITY-1:0] rd_pointer,
    output logic [ASSOCIATIVITY-1:0] rd_use,
    input  logic                     hit_valid,
    input  logic [SET_W-1:0]         hit_set,
    input  logic [ASSOCIATIVITY-1:0] hit_way,
    input  logic                     commit_valid,
    input  logic [SET_W-1:0]         commit_set,
    input  logic [ASSOCIATIVITY-1:0] commit_pointer,
    input  logic [ASSOCIATIVITY-1:0] commit_use
);

    logic [ASSOCIATIVITY-1:0] pointer_r [NUM_SETS];
    logic [ASSOCIATIVITY-1:0] use_r     [NUM_SETS];

    // A same-cycle hit to the committing set is OR'd over the committed use bits.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SETS; s++) begin
            if (rst) begin
                pointer_r[s] <= ASSOCIATIVITY'(1);
                use_r[s]     <= {ASSOCIATIVITY{1'b0}};
            end else if (commit_valid && (commit_set == SET_W'(s))) begin
                pointer_r[s] <= commit_pointer;
                use_r[s]     <= commit_use |
                                ((hit_valid && (hit_set == SET_W'(s))) ? hit_way : {ASSOCIATIVITY{1'b0}});
            end else if (hit_valid && (hit_set == SET_W'(s))) begin
                use_r[s] <= use_r[s] | hit_way;
            end else begin
                use_r[s] <= use_r[s];
            end
        end
    end

    assign rd_pointer = pointer_r[rd_set];
    assign rd_use     = use_r[rd_set];

endmodule

// File: rtl/clock_replacement_controller.sv
// Replacement-state manager: records hits, picks victims through a
// request/response handshake and commits the updated clock state on accept.
module clock_replacement_controller
    import clock_replacement_controller_pkg::*;
#(
    parameter  int ASSOCIATIVITY = DEF_ASSOCIATIVITY,
    parameter  int NUM_SETS      = DEF_NUM_SETS,
    localparam int SET_W         = $clog2(NUM_SETS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_hit_valid,
    input  logic [SET_W-1:0]         i_hit_set,
    input  logic [ASSOCIATIVITY-1:0] i_hit_way,
    input  logic                     i_victim_req_valid,
    output logic                     o_victim_req_ready,
    input  logic [SET_W-1:0]         i_victim_req_set,
    input  logic [ASSOCIATIVITY-1:0] i_victim_req_way_valid,
    output logic                     o_victim_valid,
    input  logic                     i_victim_ready,
    output logic [SET_W-1:0]         o_victim_set,
    output logic [ASSOCIATIVITY-1:0] o_victim_way,
    output logic                     o_victim_was_invalid
);

    localparam logic [ASSOCIATIVITY-1:0] ZERO_WAYS = {ASSOCIATIVITY{1'b0}};

    ctrl_state_t              state_r;
    logic [SET_W-1:0]         req_set_r;
    logic [ASSOCIATIVITY-1:0] way_valid_r;
    logic [ASSOCIATIVITY-1:0] hit_acc_r;
    logic [ASSOCIATIVITY-1:0] commit_use_r;
    logic [ASSOCIATIVITY-1:0] commit_ptr_r;
    logic                     req_ready_r;
    logic                     victim_valid_r;
    logic [SET_W-1:0]         victim_set_r;
    logic [ASSOCIATIVITY-1:0] victim_way_r;
    logic                     was_invalid_r;

    logic [ASSOCIATIVITY-1:0] rd_pointer_s, rd_use_s, lookup_use_s;
    logic [ASSOCIATIVITY-1:0] clk_mask_s, clk_use_s, first_invalid_s;
    logic                     any_invalid_s, hit_same_set_s, commit_valid_s;
    logic [ASSOCIATIVITY-1:0] victim_s, new_use_s, new_ptr_s;
    logic                     was_invalid_s;

    assign hit_same_set_s = i_hit_valid && (i_hit_set == req_set_r);
    assign lookup_use_s   = rd_use_s | (hit_same_set_s ? i_hit_way : ZERO_WAYS);
    assign commit_valid_s = (state_r == ST_RESP) && i_victim_ready;

    replacement_state_array #(.ASSOCIATIVITY(ASSOCIATIVITY), .NUM_SETS(NUM_SETS)) u_state_array (
        .clk(i_clk), .rst(i_rst),
        .rd_set(req_set_r), .rd_pointer(rd_pointer_s), .rd_use(rd_use_s),
        .hit_valid(i_hit_valid), .hit_set(i_hit_set), .hit_way(i_hit_way),
        .commit_valid(commit_valid_s), .commit_set(req_set_r),
        .commit_pointer(commit_ptr_r), .commit_use(commit_use_r | hit_acc_r)
    );

    ClockReplacement #(.ASSOCIATIVITY(ASSOCIATIVITY)) u_clock (
        .pointer(rd_pointer_s), .use_bits(lookup_use_s),
        .evicted_block_mask(clk_mask_s), .clock_use_if_evict(clk_use_s)
    );

    FindFirstOneFromLsb #(.WIDTH(ASSOCIATIVITY)) u_first_invalid (
        .vec(~way_valid_r), .first_one(first_invalid_s), .found(any_invalid_s)
    );

    // Invalid ways take priority over the clock choice and leave the pointer alone.
    always_comb begin
        victim_s      = clk_mask_s;
        new_use_s     = clk_use_s;
        new_ptr_s     = {clk_mask_s[ASSOCIATIVITY-2:0], clk_mask_s[ASSOCIATIVITY-1]};
        was_invalid_s = 1'b0;
        if (any_invalid_s) begin
            victim_s      = first_invalid_s;
            new_use_s     = lookup_use_s | first_invalid_s;
            new_ptr_s     = rd_pointer_s;
            was_invalid_s = 1'b1;
        end else begin
            was_invalid_s = 1'b0;
        end
    end

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r        <= ST_IDLE;
            req_set_r      <= {SET_W{1'b0}};
            way_valid_r    <= ZERO_WAYS;
            hit_acc_r      <= ZERO_WAYS;
            commit_use_r   <= ZERO_WAYS;
            commit_ptr_r   <= ZERO_WAYS;
            req_ready_r    <= 1'b1;
            victim_valid_r <= 1'b0;
            victim_set_r   <= {SET_W{1'b0}};
            victim_way_r   <= ZERO_WAYS;
            was_invalid_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_victim_req_valid) begin
                        req_set_r   <= i_victim_req_set;
                        way_valid_r <= i_victim_req_way_valid;
                        hit_acc_r   <= ZERO_WAYS;
                        req_ready_r <= 1'b0;
                        state_r     <= ST_LOOKUP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOOKUP: begin
                    victim_way_r   <= victim_s;
                    was_invalid_r  <= was_invalid_s;
                    victim_set_r   <= req_set_r;
                    commit_use_r   <= new_use_s;
                    commit_ptr_r   <= new_ptr_s;
                    victim_valid_r <= 1'b1;
                    state_r        <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_victim_ready) begin
                        victim_valid_r <= 1'b0;
                        req_ready_r    <= 1'b1;
                        state_r        <= ST_IDLE;
                    end else if (hit_same_set_s) begin
                        hit_acc_r <= hit_acc_r | i_hit_way;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    victim_valid_r <= 1'b0;
                    req_ready_r    <= 1'b1;
                    state_r        <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_victim_req_ready   = req_ready_r;
    assign o_victim_valid       = victim_valid_r;
    assign o_victim_set         = victim_set_r;
    assign o_victim_way         = victim_way_r;
    assign o_victim_was_invalid = was_invalid_r;

endmodule

// File: tb/tb_clock_replacement_controller.sv
// Directed bench for clock_replacement_controller (ASSOCIATIVITY=4, NUM_SETS=16).
module tb_clock_replacement_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       hit_valid;
    logic [3:0] hit_set;
    logic [3:0] hit_way;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_set;
    logic [3:0] req_way_valid;
    logic       victim_valid;
    logic       victim_ready;
    logic [3:0] victim_set;
    logic [3:0] victim_way;
    logic       victim_was_invalid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clock_replacement_controller #(.ASSOCIATIVITY(4), .NUM_SETS(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_hit_valid(hit_valid), .i_hit_set(hit_set), .i_hit_way(hit_way),
        .i_victim_req_valid(req_valid), .o_victim_req_ready(req_ready),
        .i_victim_req_set(req_set), .i_victim_req_way_valid(req_way_valid),
        .o_victim_valid(victim_valid), .i_victim_ready(victim_ready),
        .o_victim_set(victim_set), .o_victim_way(victim_way),
        .o_victim_was_invalid(victim_was_invalid)
    );

    // Hit ways must be one-hot whenever a hit is presented.
    always @(posedge clk) begin
        if (hit_valid) begin
            assert ($onehot(hit_way)) else $error("hit_way not one-hot: %b", hit_way);
        end
    end

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_hit(input logic [3:0] set, input logic [3:0] way);
        hit_valid = 1'b1;
        hit_set   = set;
        hit_way   = way;
        tick();
        hit_valid = 1'b0;
    endtask

    task automatic check_set(input string tag, input int set,
                             input logic [3:0] exp_ptr, input logic [3:0] exp_use);
        check_value({tag, "_ptr"}, 32'(dut.u_state_array.pointer_r[set]), 32'(exp_ptr));
        check_value({tag, "_use"}, 32'(dut.u_state_array.use_r[set]), 32'(exp_use));
    endtask

    // Full request/response transaction with optional LOOKUP hit and RESP stall hits.
    task automatic request(input string tag, input logic [3:0] set, input logic [3:0] wv,
                           input logic [3:0] lookup_hit, input int hold, input logic [3:0] hold_hit,
                           input logic [3:0] exp_way, input logic exp_inv);
        check_value({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid     = 1'b1;
        req_set       = set;
        req_way_valid = wv;
        tick();
        req_valid = 1'b0;
        if (lookup_hit != 4'b0000) begin
            hit_valid = 1'b1;
            hit_set   = set;
            hit_way   = lookup_hit;
        end
        check_value({tag, "_t1_valid"}, 32'(victim_valid), 32'd0);
        check_value({tag, "_t1_ready"}, 32'(req_ready), 32'd0);
        tick();
        hit_valid = 1'b0;
        check_value({tag, "_t2_valid"}, 32'(victim_valid), 32'd1);
        check_value({tag, "_way"}, 32'(victim_way), 32'(exp_way));
        check_value({tag, "_inv"}, 32'(victim_was_invalid), 32'(exp_inv));
        check_value({tag, "_set"}, 32'(victim_set), 32'(set));
        for (int i = 0; i < hold; i++) begin
            if (hold_hit != 4'b0000) begin
                hit_valid = 1'b1;
                hit_set   = set;
                hit_way   = hold_hit;
            end
            tick();
            hit_valid = 1'b0;
            check_value({tag, "_hold_valid"}, 32'(victim_valid), 32'd1);
            check_value({tag, "_hold_way"}, 32'(victim_way), 32'(exp_way));
            check_value({tag, "_hold_set"}, 32'(victim_set), 32'(set));
        end
        victim_ready = 1'b1;
        tick();
        victim_ready = 1'b0;
        check_value({tag, "_done_valid"}, 32'(victim_valid), 32'd0);
        check_value({tag, "_done_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; hit_valid = 1'b0; hit_set = 4'd0; hit_way = 4'b0000;
        req_valid = 1'b0; req_set = 4'd0; req_way_valid = 4'b0000; victim_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_value("rst_valid", 32'(victim_valid), 32'd0);
        check_value("rst_ready", 32'(req_ready), 32'd1);
        check_value("rst_set", 32'(victim_set), 32'd0);
        check_value("rst_way", 32'(victim_way), 32'd0);
        check_value("rst_inv", 32'(victim_was_invalid), 32'd0);

        // Fresh set, all valid: pointer way evicted.
        request("s2", 4'd2, 4'b1111, 4'b0000, 0, 4'b0000, 4'b0001, 1'b0);
        check_set("s2", 2, 4'b0010, 4'b0001);

        // All use bits set: pointer way chosen, others cleared.
        do_hit(4'd1, 4'b0001); do_hit(4'd1, 4'b0010); do_hit(4'd1, 4'b0100); do_hit(4'd1, 4'b1000);
        check_set("s1_hits", 1, 4'b0001, 4'b1111);
        request("s1", 4'd1, 4'b1111, 4'b0000, 0, 4'b0000, 4'b0001, 1'b0);
        check_set("s1", 1, 4'b0010, 4'b0001);

        // Second chance past ways 1,2; way 3 evicted and pointer wraps.
        request("s3a", 4'd3, 4'b1111, 4'b0000, 0, 4'b0000, 4'b0001, 1'b0);
        do_hit(4'd3, 4'b0010); do_hit(4'd3, 4'b0100);
        check_set("s3_pre", 3, 4'b0010, 4'b0111);
        request("s3b", 4'd3, 4'b1111, 4'b0000, 0, 4'b0000, 4'b1000, 1'b0);
        check_set("s3", 3, 4'b0001, 4'b1001);

        // Invalid way wins; pointer unchanged.
        request("s4", 4'd4, 4'b1011, 4'b0000, 0, 4'b0000, 4'b0100, 1'b1);
        check_set("s4", 4, 4'b0001, 4'b0100);

        // No valid ways at all: way 0.
        request("s7", 4'd7, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0001, 1'b1);
        check_set("s7", 7, 4'b0001, 4'b0001);

        // Stall in RESP with hits to way 1: outputs stable, hit kept at commit.
        request("s5", 4'd5, 4'b1111, 4'b0000, 5, 4'b0010, 4'b0001, 1'b0);
        check_set("s5", 5, 4'b0010, 4'b0011);

        // Hit in LOOKUP forwarded: way 0 gets a second chance, way 1 evicted.
        request("s6", 4'd6, 4'b1111, 4'b0001, 0, 4'b0000, 4'b0010, 1'b0);
        check_set("s6", 6, 4'b0100, 4'b0010);

        // Reset during RESP aborts the request and clears every set.
        req_valid = 1'b1; req_set = 4'd2; req_way_valid = 4'b1111;
        tick();
        req_valid = 1'b0;
        tick();
        check_value("abort_pre_valid", 32'(victim_valid), 32'd1);
        check_value("abort_pre_way", 32'(victim_way), 32'(4'b0010));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_value("abort_valid", 32'(victim_valid), 32'd0);
        check_value("abort_ready", 32'(req_ready), 32'd1);
        for (int s = 0; s < 16; s++) begin
            check_set($sformatf("abort_set%0d", s), s, 4'b0001, 4'b0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_replacement_controller.md
Name: clock_replacement_controller

Overview:
- Per-set replacement-state manager for the set-associative data cache.
- Holds one-hot clock pointer and use bits for every set.
- Records hits from the tag-compare stage.
- Serves victim requests from the miss handler through a valid/ready handshake and commits the updated state when the victim is accepted.
- Sits between tag array/miss handler and the combinational ClockReplacement policy block, which it instantiates.

Parameters:
- ASSOCIATIVITY, 4, ways per set; power of two, ≥2.
- NUM_SETS, 16, number of sets; power of two.
- SET_W, $clog2(NUM_SETS), set-index width (derived; not overridden).

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous reset, active-high
- i_hit_valid  input  1  hit touch this cycle
- i_hit_set  input  SET_W  set index of hit
- i_hit_way  input  ASSOCIATIVITY  one-hot way that hit
- i_victim_req_valid  input  1  miss handler requests a victim
- o_victim_req_ready  output  1  controller can accept a request (IDLE)
- i_victim_req_set  input  SET_W  set needing a victim
- i_victim_req_way_valid  input  ASSOCIATIVITY  tag-array valid bits of that set
- o_victim_valid  output  1  victim response valid
- i_victim_ready  input  1  miss handler accepts response; commits state
- o_victim_set  output  SET_W  set of the response
- o_victim_way  output  ASSOCIATIVITY  one-hot victim way
- o_victim_was_invalid  output  1  victim chosen from an invalid way

Behaviour:
- Reset
  - One clock and one reset: synchronous, active-high.
  - On i_rst, every set is cleared: pointer = 1 (way 0), use = 0.
  - FSM goes to IDLE.
  - Output reset values: o_victim_valid = 0, o_victim_req_ready = 1, o_victim_set = 0, o_victim_way = 0, o_victim_was_invalid = 0.
  - Reset is legal in any state; it aborts the request with no commit.
- FSM states
  - IDLE: o_victim_req_ready = 1. On i_victim_req_valid, latch set and way_valid, then go to LOOKUP.
  - LOOKUP (1 cycle): read pointer and use bits of the latched set. Compute the victim, register it, and go to RESP.
  - RESP: o_victim_valid = 1. Outputs stay stable until i_victim_ready. On that handshake, commit state and go to IDLE.
- Timing
  - Request accepted at cycle T; o_victim_valid rises at T+2.
  - Next request can be accepted the cycle after the handshake.
- Victim selection
  - If way_valid is not all ones, the victim is the lowest-index invalid way. o_victim_was_invalid = 1.
  - Otherwise the victim is the ClockReplacement evicted_block_mask for the set's pointer and use bits. o_victim_was_invalid = 0.
  - If all use bits are set, the pointer way is chosen.
- Commit
  - Clock victim: use ← clock_use_if_evict. Pointer ← victim rotated left by 1, so the MSB way wraps to way 0.
  - Invalid victim: use ← use | victim. Pointer is unchanged.
- Hits
  - When i_hit_valid is high, the use bit of i_hit_way in set i_hit_set is set on the next edge. Hits are accepted in every state and never stall.
  - A hit in the LOOKUP cycle to the latched set is forwarded into the victim computation (use | hit_way).
  - Hits to the latched set during RESP are accumulated. At commit, the written use bits = commit value | accumulated hits.
  - A hit in the commit cycle to the same set is also OR'd in.
- Illegal inputs
  - i_hit_way must be one-hot when i_hit_valid is high; behaviour for other values is undefined and a bench assertion flags it.
  - i_victim_req_way_valid is only sampled at acceptance.

Decomposition:
- Shared cache package holds:
  - ASSOCIATIVITY / NUM_SETS defaults.
  - The state-enum typedef (IDLE, LOOKUP, RESP).
  - A per-set state struct {pointer, use}.
- Reuse the existing ClockReplacement and FindFirstOneFromLsb; the latter selects the lowest invalid way.
- One natural sub-module, replacement_state_array:
  - NUM_SETS pointer/use registers.
  - One read port and the hit/commit write ports.
  - Hit-and-commit merge logic.

Test Plan (ASSOCIATIVITY=4, NUM_SETS=16):
- Reset, then request set 2 with way_valid=1111 → o_victim_valid at T+2, victim=0001. After commit, set 2 has pointer=0010, use=0001.
- Hits to ways 0–3 of set 1, then request set 1, way_valid=1111 → victim=0001. After commit, use=0001, pointer=0010.
- Set 3 preloaded with pointer=0010, use=0110 → victim=1000. After commit, use=1000, pointer wraps to 0001.
- Request set 4 with way_valid=1011 → victim=0100, was_invalid=1. After commit, pointer unchanged, use bit 2 set.
- i_victim_ready held low 5 cycles while hitting way 1 of the latched set in RESP → outputs stable throughout. After commit, use bit 1 is set.
- Assert i_rst during RESP → next cycle o_victim_valid=0, o_victim_req_ready=1, and all sets have pointer=0001, use=0000.
